// File: rtl/dodge_core.sv
// Falling-object dodge game: the player holds the bottom two rows, objects rain down at
// LFSR-chosen columns, and the playfield is read out one active-low column at a time.
module dodge_core #(
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned NOBJ  = 3,
    parameter int unsigned LIVES = 3,
    parameter int unsigned INV   = 4
) (
    input  logic                    CLK,
    input  logic                    clear,
    input  logic                    step,
    input  logic                    sec_tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    Left,
    input  logic                    Right,
    input  logic [$clog2(COLS)-1:0] col_sel,
    output logic [ROWS-1:0]         col_obj,
    output logic [ROWS-1:0]         col_ply,
    output logic [2:0]              lives,
    output logic [3:0]              score_s,
    output logic [3:0]              score_m,
    output logic [2:0]              level,
    output logic [1:0]              state,
    output logic                    hit
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned WW = 4;
    localparam int unsigned IW = $clog2(INV + 2);
    localparam logic [15:0] SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_e;

    function automatic logic [NOBJ-1:0][WW-1:0] stagger_init();
        logic [NOBJ-1:0][WW-1:0] w;
        for (int i = 0; i < int'(NOBJ); i++) w[i] = WW'(2 * i);
        return w;
    endfunction

    localparam logic [NOBJ-1:0][WW-1:0] WT_INIT = stagger_init();

    state_e                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    pause_q;
    logic [CW-1:0]           pcol_q, pcol_d;
    logic [NOBJ-1:0]         act_q, act_d;
    logic [NOBJ-1:0][YW-1:0] y_q, y_d;
    logic [NOBJ-1:0][CW-1:0] x_q, x_d;
    logic [NOBJ-1:0][2:0]    fc_q, fc_d;
    logic [NOBJ-1:0][WW-1:0] wt_q, wt_d;
    logic [IW-1:0]           inv_q, inv_d;
    logic [2:0]              lives_q, lives_d;
    logic [2:0]              level_q, level_d;
    logic [3:0]              ss_q, ss_d;
    logic [3:0]              sm_q, sm_d;
    logic                    hit_q, hit_d;
    logic [ROWS-1:0]         cobj_q, cobj_d;
    logic [ROWS-1:0]         cply_q, cply_d;

    logic       pause_rise, game_upd, sec_upd, restart, lose, coll;
    logic [2:0] plim;

    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign pause_rise = pause & ~pause_q;
    assign game_upd   = step && (state_q == S_RUN);
    assign sec_upd    = sec_tick && (state_q == S_RUN);
    assign restart    = start && ((state_q == S_IDLE) || (state_q == S_OVER));
    assign lose       = game_upd && (lives_q != 3'd0) && (lives_d == 3'd0);
    // Steps per row minus one: period is 8 - level, never below 1.
    assign plim       = 3'd7 - level_q;

    // State and datapath registers
    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            pause_q <= 1'b0;
            pcol_q  <= CW'(COLS / 2 - 1);
            act_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            fc_q    <= '0;
            wt_q    <= WT_INIT;
            inv_q   <= '0;
            lives_q <= 3'(LIVES);
            level_q <= '0;
            ss_q    <= '0;
            sm_q    <= '0;
            hit_q   <= 1'b0;
            cobj_q  <= '1;
            cply_q  <= '1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            pause_q <= pause;
            pcol_q  <= pcol_d;
            act_q   <= act_d;
            y_q     <= y_d;
            x_q     <= x_d;
            fc_q    <= fc_d;
            wt_q    <= wt_d;
            inv_q   <= inv_d;
            lives_q <= lives_d;
            level_q <= level_d;
            ss_q    <= ss_d;
            sm_q    <= sm_d;
            hit_q   <= hit_d;
            cobj_q  <= cobj_d;
            cply_q  <= cply_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (lose) state_d = S_OVER;
                else if (pause_rise) state_d = S_PAUSE;
            end
            S_PAUSE: if (pause_rise) state_d = S_RUN;
            S_OVER:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Game update: move, fall/spawn, collide, then score
    always_comb begin
        pcol_d  = pcol_q;
        act_d   = act_q;
        y_d     = y_q;
        x_d     = x_q;
        fc_d    = fc_q;
        wt_d    = wt_q;
        inv_d   = inv_q;
        lives_d = lives_q;
        level_d = level_q;
        ss_d    = ss_q;
        sm_d    = sm_q;
        hit_d   = 1'b0;
        coll    = 1'b0;
        if (restart) begin
            pcol_d  = CW'(COLS / 2 - 1);
            act_d   = '0;
            y_d     = '0;
            x_d     = '0;
            fc_d    = '0;
            wt_d    = WT_INIT;
            inv_d   = '0;
            lives_d = 3'(LIVES);
            level_d = '0;
            ss_d    = '0;
            sm_d    = '0;
        end else begin
            if (game_upd) begin
                if (Right && !Left && (pcol_q != CW'(COLS - 1))) pcol_d = pcol_q + 1'b1;
                else if (Left && !Right && (pcol_q != '0)) pcol_d = pcol_q - 1'b1;
                for (int i = 0; i < int'(NOBJ); i++) begin
                    if (!act_q[i]) begin
                        if (wt_q[i] == '0) begin
                            act_d[i] = 1'b1;
                            y_d[i]   = '0;
                            fc_d[i]  = '0;
                            x_d[i]   = lfsr_q[CW-1:0];
                        end else begin
                            wt_d[i] = wt_q[i] - 1'b1;
                        end
                    end else if (fc_q[i] >= plim) begin
                        fc_d[i] = '0;
                        if (y_q[i] == YW'(ROWS - 1)) begin
                            y_d[i] = '0;
                            x_d[i] = lfsr_q[CW-1:0];
                        end else begin
                            y_d[i] = y_q[i] + 1'b1;
                        end
                    end else begin
                        fc_d[i] = fc_q[i] + 1'b1;
                    end
                    if (act_d[i] && (x_d[i] == pcol_d) && (y_d[i] >= YW'(ROWS - 2))) coll = 1'b1;
                end
                // Any number of overlapping objects costs a single life.
                if (inv_q != '0) begin
                    inv_d = inv_q - 1'b1;
                end else if (coll) begin
                    hit_d   = 1'b1;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    inv_d   = IW'(INV);
                    act_d   = '0;
                    y_d     = '0;
                    fc_d    = '0;
                    wt_d    = WT_INIT;
                end
            end
            if (sec_upd) begin
                if (ss_q == 4'd9) begin
                    ss_d = 4'd0;
                    sm_d = (sm_q == 4'd9) ? 4'd0 : sm_q + 4'd1;
                    if (level_q != 3'd7) level_d = level_q + 3'd1;
                end else begin
                    ss_d = ss_q + 4'd1;
                end
            end
        end
    end

    // Display column readout
    always_comb begin
        cobj_d = '1;
        cply_d = '1;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (state_q == S_OVER) begin
                if ((r == int'(col_sel)) || (r == int'(COLS) - 1 - int'(col_sel))) cobj_d[r] = 1'b0;
            end else begin
                for (int i = 0; i < int'(NOBJ); i++) begin
                    if (act_q[i] && (x_q[i] == col_sel) && (int'(y_q[i]) == r)) cobj_d[r] = 1'b0;
                end
                if ((pcol_q == col_sel) && (r >= int'(ROWS) - 2)) cply_d[r] = 1'b0;
            end
        end
    end

    assign col_obj = cobj_q;
    assign col_ply = cply_q;
    assign lives   = lives_q;
    assign score_s = ss_q;
    assign score_m = sm_q;
    assign level   = level_q;
    assign state   = state_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_dodge_core.sv
// Scoreboard bench for dodge_core: drivers update a behavioural game model and queue the
// expected outputs; a negedge monitor pops and compares them.
module tb_dodge_core;
    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int NOBJ = 3;
    localparam int INV  = 4;

    logic       CLK = 1'b0;
    logic       clear = 1'b0;
    logic       step = 1'b0;
    logic       sec_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       Left = 1'b0;
    logic       Right = 1'b0;
    logic [2:0] col_sel = 3'd3;
    logic [7:0] col_obj, col_ply;
    logic [2:0] lives, level;
    logic [3:0] score_s, score_m;
    logic [1:0] state;
    logic       hit;

    dodge_core dut (
        .CLK(CLK), .clear(clear), .step(step), .sec_tick(sec_tick), .start(start),
        .pause(pause), .Left(Left), .Right(Right), .col_sel(col_sel),
        .col_obj(col_obj), .col_ply(col_ply), .lives(lives), .score_s(score_s),
        .score_m(score_m), .level(level), .state(state), .hit(hit)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      nm;
        bit         hit;
        int         lives;
        int         st;
        int         ss;
        int         sm;
        int         lvl;
        bit         dchk;
        logic [7:0] co;
        logic [7:0] cp;
    } rec_t;

    rec_t  exp_q[$];
    rec_t  e;
    int    checks = 0;
    int    errors = 0;
    int    hit_cnt = 0;
    string cur = "init";

    // Reference game model
    logic [15:0] m_lfsr = 16'hACE1;
    int m_state = 0, m_lives = 3, m_level = 0, m_ss = 0, m_sm = 0, m_pcol = 3, m_inv = 0;
    int m_act[NOBJ], m_y[NOBJ], m_x[NOBJ], m_fc[NOBJ], m_wt[NOBJ];

    always @(posedge CLK or negedge clear) begin
        if (!clear) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic m_init();
        m_lives = 3; m_level = 0; m_ss = 0; m_sm = 0; m_pcol = COLS / 2 - 1; m_inv = 0;
        for (int i = 0; i < NOBJ; i++) begin
            m_act[i] = 0; m_y[i] = 0; m_x[i] = 0; m_fc[i] = 0; m_wt[i] = 2 * i;
        end
    endtask

    task automatic m_step(input bit l, input bit r, output bit h);
        bit any;
        h = 1'b0;
        any = 1'b0;
        if (m_state != 1) return;
        if (r && !l && m_pcol < COLS - 1) m_pcol++;
        else if (l && !r && m_pcol > 0) m_pcol--;
        for (int i = 0; i < NOBJ; i++) begin
            if (m_act[i] == 0) begin
                if (m_wt[i] == 0) begin
                    m_act[i] = 1; m_y[i] = 0; m_fc[i] = 0; m_x[i] = int'(m_lfsr[2:0]);
                end else m_wt[i]--;
            end else if (m_fc[i] >= 7 - m_level) begin
                m_fc[i] = 0;
                m_y[i]++;
                if (m_y[i] == ROWS) begin
                    m_y[i] = 0; m_x[i] = int'(m_lfsr[2:0]);
                end
            end else m_fc[i]++;
            if (m_act[i] == 1 && m_x[i] == m_pcol && m_y[i] >= ROWS - 2) any = 1'b1;
        end
        if (m_inv > 0) m_inv--;
        else if (any) begin
            h = 1'b1;
            if (m_lives > 0) m_lives--;
            m_inv = INV;
            for (int i = 0; i < NOBJ; i++) begin
                m_act[i] = 0; m_y[i] = 0; m_fc[i] = 0; m_wt[i] = 2 * i;
            end
            if (m_lives == 0) m_state = 3;
        end
    endtask

    task automatic m_sec();
        if (m_state != 1) return;
        if (m_ss == 9) begin
            m_ss = 0;
            m_sm = (m_sm + 1) % 10;
            if (m_level < 7) m_level++;
        end else m_ss++;
    endtask

    task automatic m_disp(input int cs, output logic [7:0] co, output logic [7:0] cp);
        co = 8'hFF;
        cp = 8'hFF;
        if (m_state == 3) begin
            co[cs] = 1'b0;
            co[COLS - 1 - cs] = 1'b0;
        end else begin
            for (int i = 0; i < NOBJ; i++)
                if (m_act[i] == 1 && m_x[i] == cs) co[m_y[i]] = 1'b0;
            if (m_pcol == cs) begin
                cp[ROWS - 2] = 1'b0;
                cp[ROWS - 1] = 1'b0;
            end
        end
    endtask

    task automatic push_rec(input bit h, input bit dchk, input bit ovr,
                            input logic [7:0] oco, input logic [7:0] ocp);
        rec_t r;
        r.nm = cur; r.hit = h; r.lives = m_lives; r.st = m_state;
        r.ss = m_ss; r.sm = m_sm; r.lvl = m_level; r.dchk = dchk;
        m_disp(int'(col_sel), r.co, r.cp);
        if (ovr) begin
            r.co = oco;
            r.cp = ocp;
        end
        exp_q.push_back(r);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, want);
        end
    endtask

    // Monitor: one expected record per negedge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.nm, ".hit"}, int'(hit), int'(e.hit));
            chk({e.nm, ".lives"}, int'(lives), e.lives);
            chk({e.nm, ".state"}, int'(state), e.st);
            chk({e.nm, ".score_s"}, int'(score_s), e.ss);
            chk({e.nm, ".score_m"}, int'(score_m), e.sm);
            chk({e.nm, ".level"}, int'(level), e.lvl);
            if (e.dchk) begin
                chk({e.nm, ".col_obj"}, int'(col_obj), int'(e.co));
                chk({e.nm, ".col_ply"}, int'(col_ply), int'(e.cp));
            end
        end
    end

    always @(negedge CLK) if (hit === 1'b1) hit_cnt++;

    task automatic sync();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic tick(input bit st, input bit sc, input bit l, input bit rr, input int cs);
        bit h;
        sync();
        col_sel = 3'(cs); step = st; sec_tick = sc; Left = l; Right = rr;
        h = 1'b0;
        if (st) m_step(l, rr, h);
        if (sc) m_sec();
        @(posedge CLK); #1;
        step = 1'b0; sec_tick = 1'b0; Left = 1'b0; Right = 1'b0;
        push_rec(h, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge CLK); #1;
        push_rec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_start();
        sync();
        start = 1'b1;
        if (m_state == 0 || m_state == 3) begin
            m_init();
            m_state = 1;
        end
        @(posedge CLK); #1;
        start = 1'b0;
        push_rec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge CLK); #1;
        push_rec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_pause_edge();
        sync();
        pause = 1'b1;
        if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 1;
        @(posedge CLK); #1;
        push_rec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge CLK); #1;
        push_rec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        sync();
        clear = 1'b0;
        m_state = 0;
        m_init();
        #1;
        push_rec(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        @(posedge CLK); #1;
        clear = 1'b1;
        @(posedge CLK); #1;
        push_rec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        int n;
        m_init();
        repeat (2) @(posedge CLK);
        #1;
        cur = "reset";
        push_rec(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        @(posedge CLK); #1;
        clear = 1'b1;
        @(posedge CLK); #1;
        cur = "idle";
        push_rec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

        cur = "start1";
        do_start();
        cur = "quiet20";
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, k % 8);

        cur = "left_edge";
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
        cur = "left_right";
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1);

        cur = "sec10";
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cur = "sec99";
        for (int k = 0; k < 89; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cur = "sec_wrap";
        tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cur = "step_and_sec";
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0);

        cur = "crash";
        n = 0;
        while (m_state != 3 && n < 800) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, n % 8);
            n++;
        end
        if (m_state != 3) begin
            errors++;
            $display("FAIL crash_timeout model did not reach game over within %0d steps", n);
        end
        chk("hit_pulses", hit_cnt, 3);

        cur = "over";
        tick(1'b1, 1'b0, 1'b0, 1'b1, 2);
        sync();
        push_rec(1'b0, 1'b1, 1'b1, 8'hDB, 8'hFF);

        cur = "restart";
        do_start();
        cur = "prepause";
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0, 1'b1, k);
        cur = "pause";
        do_pause_edge();
        cur = "paused";
        for (int k = 0; k < 50; k++) tick(1'b1, (k % 10) == 0, 1'b1, 1'b0, k % 8);
        pause = 1'b0;
        cur = "clear";
        do_reset();
        cur = "after_clear";
        tick(1'b1, 1'b1, 1'b0, 1'b0, 3);

        sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
